// File: rtl/keypad_code_entry.sv
// keypad_code_entry: collects keypad digits into a code and sends it to the
// password checker over a req/ack handshake. It drives the unlocked flag and
// applies a timed lockout after repeated failures.
// Optional feature macro: AUTO_RELOCK_EN. When it is defined, the block relocks
// after UNLOCK_CYC idle cycles in the unlocked state.
module keypad_code_entry #(
    parameter int CODE_W      = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int UNLOCK_CYC  = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_data,
    output logic              key_ready,
    output logic [CODE_W-1:0] pass_input,
    output logic              pass_req,
    input  logic              pass_ack,
    input  logic              pass_check,
    output logic              unlocked,
    output logic              locked_out,
    output logic [3:0]        fail_cnt
);

    localparam int N      = CODE_W / 4;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
`ifdef AUTO_RELOCK_EN
    localparam int IDLE_W = $clog2(UNLOCK_CYC + 1);
`endif

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_REQ,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    digit_cnt;
    logic [LOCK_W-1:0]   lock_timer;
`ifdef AUTO_RELOCK_EN
    logic [IDLE_W-1:0]   idle_timer;
`endif

    logic                key_fire;
    logic                is_digit;
    logic [CODE_W+3:0]   shifted;
    logic [3:0]          fail_next;

    // Key acceptance decode and the shifted code for an incoming digit.
    always_comb begin
        key_fire  = key_valid & key_ready;
        is_digit  = (key_data <= 4'd9);
        shifted   = {pass_input, key_data};
        fail_next = fail_cnt + 4'd1;
    end

    // Main control FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_COLLECT;
            pass_input <= '0;
            digit_cnt  <= '0;
            pass_req   <= 1'b0;
            key_ready  <= 1'b1;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= 4'd0;
            lock_timer <= '0;
`ifdef AUTO_RELOCK_EN
            idle_timer <= '0;
`endif
        end else begin
            case (state)
                S_COLLECT, S_UNLOCKED: begin
                    if (key_fire) begin
`ifdef AUTO_RELOCK_EN
                        idle_timer <= '0;
`endif
                        if (is_digit) begin
                            pass_input <= shifted[CODE_W-1:0];
                            if (digit_cnt != CNT_W'(N))
                                digit_cnt <= digit_cnt + 1'b1;
                        end else if (key_data == KEY_CLEAR) begin
                            pass_input <= '0;
                            digit_cnt  <= '0;
                            if (state == S_UNLOCKED && digit_cnt == '0) begin
                                unlocked <= 1'b0;
                                state    <= S_COLLECT;
                            end
                        end else if (key_data == KEY_ENTER) begin
                            if (digit_cnt == CNT_W'(N)) begin
                                state     <= S_REQ;
                                pass_req  <= 1'b1;
                                key_ready <= 1'b0;
                            end else begin
                                pass_input <= '0;
                                digit_cnt  <= '0;
                            end
                        end
                    end
`ifdef AUTO_RELOCK_EN
                    else if (state == S_UNLOCKED) begin
                        if (idle_timer == IDLE_W'(UNLOCK_CYC - 1)) begin
                            unlocked   <= 1'b0;
                            pass_input <= '0;
                            digit_cnt  <= '0;
                            idle_timer <= '0;
                            state      <= S_COLLECT;
                        end else begin
                            idle_timer <= idle_timer + 1'b1;
                        end
                    end
`endif
                end

                S_REQ: begin
                    if (pass_ack) begin
                        pass_req   <= 1'b0;
                        pass_input <= '0;
                        digit_cnt  <= '0;
                        if (pass_check) begin
                            unlocked  <= 1'b1;
                            fail_cnt  <= 4'd0;
                            key_ready <= 1'b1;
                            state     <= S_UNLOCKED;
`ifdef AUTO_RELOCK_EN
                            idle_timer <= '0;
`endif
                        end else begin
                            unlocked <= 1'b0;
                            fail_cnt <= fail_next;
                            if (fail_next == 4'(MAX_FAILS)) begin
                                locked_out <= 1'b1;
                                lock_timer <= '0;
                                key_ready  <= 1'b0;
                                state      <= S_LOCKOUT;
                            end else begin
                                key_ready <= 1'b1;
                                state     <= S_COLLECT;
                            end
                        end
                    end
                end

                S_LOCKOUT: begin
                    if (lock_timer == LOCK_W'(LOCK_CYCLES - 1)) begin
                        locked_out <= 1'b0;
                        fail_cnt   <= 4'd0;
                        key_ready  <= 1'b1;
                        state      <= S_COLLECT;
                    end else begin
                        lock_timer <= lock_timer + 1'b1;
                    end
                end

                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: directed test of keypad_code_entry with hand-computed
// expected values. Inputs change on the falling edge; outputs are sampled there too.
module tb_keypad_code_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_ready;
    logic [7:0] pass_input;
    logic       pass_req;
    logic       pass_ack;
    logic       pass_check;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] fail_cnt;

    int vectors;
    int miscompares;
    int n;

    keypad_code_entry #(
        .CODE_W(8),
        .MAX_FAILS(3),
        .LOCK_CYCLES(1000),
        .UNLOCK_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_data(key_data),
        .key_ready(key_ready),
        .pass_input(pass_input),
        .pass_req(pass_req),
        .pass_ack(pass_ack),
        .pass_check(pass_check),
        .unlocked(unlocked),
        .locked_out(locked_out),
        .fail_cnt(fail_cnt)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_data  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_data  = 4'h0;
    endtask

    task automatic submitCode(input logic [3:0] d1, input logic [3:0] d2, input logic chk);
        applyStimulus(d1);
        applyStimulus(d2);
        applyStimulus(4'hF);
        pass_ack   = 1'b1;
        pass_check = chk;
        @(negedge clk);
        pass_ack   = 1'b0;
        pass_check = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, 32'(key_ready), 32'd1);
        checkOutput({tag, "_req"}, 32'(pass_req), 32'd0);
        checkOutput({tag, "_unl"}, 32'(unlocked), 32'd0);
        checkOutput({tag, "_lock"}, 32'(locked_out), 32'd0);
        checkOutput({tag, "_fail"}, 32'(fail_cnt), 32'd0);
        checkOutput({tag, "_code"}, 32'(pass_input), 32'h00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key_valid   = 1'b0;
        key_data    = 4'h0;
        pass_ack    = 1'b0;
        pass_check  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkIdle("reset");

        // T1: 4,2,F then success in the second REQ cycle
        applyStimulus(4'h4);
        applyStimulus(4'h2);
        applyStimulus(4'hF);
        checkOutput("t1_req", 32'(pass_req), 32'd1);
        checkOutput("t1_ready", 32'(key_ready), 32'd0);
        checkOutput("t1_code", 32'(pass_input), 32'h42);
        @(negedge clk);
        checkOutput("t1_req_hold", 32'(pass_req), 32'd1);
        pass_ack   = 1'b1;
        pass_check = 1'b1;
        @(negedge clk);
        pass_ack   = 1'b0;
        pass_check = 1'b0;
        checkOutput("t1_unl", 32'(unlocked), 32'd1);
        checkOutput("t1_fail", 32'(fail_cnt), 32'd0);
        checkOutput("t1_req_drop", 32'(pass_req), 32'd0);
        checkOutput("t1_ready_back", 32'(key_ready), 32'd1);

        // T5: clear with non-empty buffer keeps access, with empty buffer relocks
        applyStimulus(4'h5);
        checkOutput("t5_digit", 32'(pass_input), 32'h05);
        applyStimulus(4'hE);
        checkOutput("t5_clr_unl", 32'(unlocked), 32'd1);
        checkOutput("t5_clr_code", 32'(pass_input), 32'h00);
        applyStimulus(4'hE);
        checkOutput("t5_relock", 32'(unlocked), 32'd0);
        pass_ack   = 1'b1;
        pass_check = 1'b1;
        @(negedge clk);
        pass_ack   = 1'b0;
        pass_check = 1'b0;
        @(negedge clk);
        checkOutput("t5_stray_ack_unl", 32'(unlocked), 32'd0);
        checkOutput("t5_stray_ack_req", 32'(pass_req), 32'd0);

        // T3: short code is discarded, then last two of three digits win
        applyStimulus(4'h7);
        applyStimulus(4'hF);
        checkOutput("t3_short_req", 32'(pass_req), 32'd0);
        checkOutput("t3_short_code", 32'(pass_input), 32'h00);
        applyStimulus(4'h9);
        applyStimulus(4'hA);
        applyStimulus(4'h8);
        checkOutput("t3_ignore_a", 32'(pass_input), 32'h98);
        applyStimulus(4'hE);
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'h3);
        checkOutput("t3_shift", 32'(pass_input), 32'h23);
        applyStimulus(4'hF);
        checkOutput("t3_req", 32'(pass_req), 32'd1);
        checkOutput("t3_code", 32'(pass_input), 32'h23);
        repeat (10) @(negedge clk);
        checkOutput("t3_wait", 32'(pass_req), 32'd1);
        checkOutput("t3_wait_code", 32'(pass_input), 32'h23);
        pass_ack   = 1'b1;
        pass_check = 1'b0;
        @(negedge clk);
        pass_ack = 1'b0;
        checkOutput("t3_fail_cnt", 32'(fail_cnt), 32'd1);
        checkOutput("t3_fail_req", 32'(pass_req), 32'd0);
        checkOutput("t3_fail_code", 32'(pass_input), 32'h00);

        // T4: reset during an outstanding request
        applyStimulus(4'h1);
        applyStimulus(4'h1);
        applyStimulus(4'hF);
        checkOutput("t4_req", 32'(pass_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("t4_rst");
        rst = 1'b0;

        // T2: three failures lead to a 1000-cycle lockout; ack in first REQ cycle
        submitCode(4'h1, 4'h1, 1'b0);
        checkOutput("t2_fail1", 32'(fail_cnt), 32'd1);
        checkOutput("t2_lock1", 32'(locked_out), 32'd0);
        submitCode(4'h1, 4'h1, 1'b0);
        checkOutput("t2_fail2", 32'(fail_cnt), 32'd2);
        submitCode(4'h1, 4'h1, 1'b0);
        checkOutput("t2_fail3", 32'(fail_cnt), 32'd3);
        checkOutput("t2_lock", 32'(locked_out), 32'd1);
        checkOutput("t2_ready", 32'(key_ready), 32'd0);
        key_valid = 1'b1;
        key_data  = 4'h5;
        n = 0;
        while (locked_out && n < 1100) begin
            @(negedge clk);
            n++;
        end
        key_valid = 1'b0;
        key_data  = 4'h0;
        checkOutput("t2_lock_len", 32'(n), 32'd1000);
        checkOutput("t2_keys_refused", 32'(pass_input), 32'h00);
        checkOutput("t2_fail_clr", 32'(fail_cnt), 32'd0);
        checkOutput("t2_ready_back", 32'(key_ready), 32'd1);

        // Unlock again, then a failed re-verify drops access
        submitCode(4'h4, 4'h2, 1'b1);
        checkOutput("rv_unl", 32'(unlocked), 32'd1);
        applyStimulus(4'h1);
        applyStimulus(4'h1);
        applyStimulus(4'hF);
        checkOutput("rv_req", 32'(pass_req), 32'd1);
        checkOutput("rv_unl_hold", 32'(unlocked), 32'd1);
        pass_ack   = 1'b1;
        pass_check = 1'b0;
        @(negedge clk);
        pass_ack = 1'b0;
        checkOutput("rv_drop", 32'(unlocked), 32'd0);
        checkOutput("rv_fail", 32'(fail_cnt), 32'd1);

`ifdef AUTO_RELOCK_EN
        // T6: idle relock after 50 cycles, restarted by a key at cycle 49
        submitCode(4'h4, 4'h2, 1'b1);
        checkOutput("t6_unl", 32'(unlocked), 32'd1);
        n = 0;
        while (unlocked && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_idle", 32'(n), 32'd50);
        submitCode(4'h4, 4'h2, 1'b1);
        repeat (48) @(negedge clk);
        key_valid = 1'b1;
        key_data  = 4'h5;
        n = 48;
        @(negedge clk);
        n++;
        key_valid = 1'b0;
        key_data  = 4'h0;
        while (unlocked && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_restart", 32'(n), 32'd99);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
